// File: rtl/lock_pkg.sv
// Shared state encoding and default parameters for the safe-lock code path.
package lock_pkg;

  typedef enum logic [1:0] {
    RECV  = 2'd0,
    CHECK = 2'd1,
    OPEN  = 2'd2,
    LOCK  = 2'd3
  } lock_state_t;

  localparam int          DEF_N              = 4;
  localparam int          DEF_DIGITS         = 4;
  localparam logic [15:0] DEF_RESET_CODE     = 16'h1234;
  localparam int          DEF_MAX_TRIES      = 3;
  localparam int          DEF_LOCKOUT_CYCLES = 16;

endpackage

// File: rtl/lockout_timer.sv
// Down-counter for the lockout window: load starts it, done flags its final cycle.
module lockout_timer #(
  parameter int LOCKOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic done,
  output logic active
);

  localparam int CW = $clog2(LOCKOUT_CYCLES);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      active <= 1'b0;
    end else if (load) begin
      cnt    <= CW'(LOCKOUT_CYCLES - 1);
      active <= 1'b1;
    end else if (active) begin
      if (cnt == '0) active <= 1'b0;
      else           cnt    <= cnt - 1'b1;
    end
  end

  // Loaded value L-1 counting down to 0 keeps active high for exactly L cycles.
  assign done = active && (cnt == '0);

endmodule

// File: rtl/s2p_code_check.sv
// Serial code receiver: assembles W MSB-first bits, compares against the stored
// code, and manages unlock, consecutive-failure counting and timed lockout.
module s2p_code_check
  import lock_pkg::*;
#(
  parameter int                     N              = DEF_N,
  parameter int                     DIGITS         = DEF_DIGITS,
  parameter logic [N*DIGITS-1:0]    RESET_CODE     = DEF_RESET_CODE,
  parameter int                     MAX_TRIES      = DEF_MAX_TRIES,
  parameter int                     LOCKOUT_CYCLES = DEF_LOCKOUT_CYCLES
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ser_valid,
  input  logic                  ser_data,
  output logic                  ser_ready,
  input  logic                  clear,
  input  logic                  relock,
  input  logic                  set_code,
  input  logic [N*DIGITS-1:0]   new_code,
  output logic                  unlocked,
  output logic                  lockout,
  output logic                  match,
  output logic                  fail,
  output logic                  alarm
);

  localparam int W   = N * DIGITS;
  localparam int BCW = $clog2(W);
  localparam int FCW = $clog2(MAX_TRIES + 1);

  lock_state_t    state;
  logic [W-1:0]   word;
  logic [W-1:0]   stored;
  logic [BCW-1:0] bit_cnt;
  logic [FCW-1:0] fail_cnt;
  logic [FCW-1:0] fail_nxt;
  logic           accept;
  logic           last_bit;
  logic           code_ok;
  logic           lock_hit;
  logic           tmr_load;
  logic           tmr_done;

  assign accept   = ser_valid && ser_ready;
  assign last_bit = (bit_cnt == BCW'(W - 1));
  assign code_ok  = (word == stored);
  assign fail_nxt = fail_cnt + 1'b1;
  assign lock_hit = (fail_nxt == FCW'(MAX_TRIES));
  assign tmr_load = (state == CHECK) && !code_ok && lock_hit;

  lockout_timer #(
    .LOCKOUT_CYCLES (LOCKOUT_CYCLES)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .load   (tmr_load),
    .done   (tmr_done),
    .active (lockout)
  );

  assign ser_ready = (state == RECV);
  assign unlocked  = (state == OPEN);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= RECV;
      word     <= '0;
      stored   <= RESET_CODE;
      bit_cnt  <= '0;
      fail_cnt <= '0;
      match    <= 1'b0;
      fail     <= 1'b0;
      alarm    <= 1'b0;
    end else begin
      match <= 1'b0;
      fail  <= 1'b0;
      alarm <= 1'b0;
      case (state)
        RECV: begin
          // clear outranks a coincident accepted bit; the bit is dropped
          if (clear) begin
            bit_cnt <= '0;
          end else if (accept) begin
            word <= {word[W-2:0], ser_data};
            if (last_bit) begin
              bit_cnt <= '0;
              state   <= CHECK;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        CHECK: begin
          if (code_ok) begin
            match    <= 1'b1;
            fail_cnt <= '0;
            state    <= OPEN;
          end else if (lock_hit) begin
            fail     <= 1'b1;
            alarm    <= 1'b1;
            fail_cnt <= '0;
            state    <= LOCK;
          end else begin
            fail     <= 1'b1;
            fail_cnt <= fail_nxt;
            state    <= RECV;
          end
        end
        OPEN: begin
          if (set_code) stored <= new_code;
          if (relock)   state  <= RECV;
        end
        LOCK: begin
          if (tmr_done) state <= RECV;
        end
        default: state <= RECV;
      endcase
    end
  end

endmodule

// File: doc/s2p_code_check.md
# s2p_code_check

Serial-to-parallel receiver and code comparator for the safe lock. It sits directly downstream of the keypad serializer and consumes its MSB-first `ser_valid`/`ser_data`/`ser_ready` bit stream. It assembles `DIGITS` digits of `N` bits each into one code word, compares the word against a stored code, and drives unlock, failed-attempt counting and timed lockout.

## Interface
- `N`, 4: bits per digit.
- `DIGITS`, 4: digits per code; code width `W = N*DIGITS`.
- `RESET_CODE`, 16'h1234: stored code after reset (width `W`).
- `MAX_TRIES`, 3: consecutive failures that trigger lockout (≥1).
- `LOCKOUT_CYCLES`, 16: lockout duration in clocks (≥2).

Ports:
- `clk` in 1: single clock, all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `ser_valid` in 1: upstream bit valid.
- `ser_data` in 1: serial bit, MSB of the code first.
- `ser_ready` out 1: block accepts a bit this cycle.
- `clear` in 1: discard the partial entry.
- `relock` in 1: leave the unlocked state.
- `set_code` in 1: load `new_code` as the stored code.
- `new_code` in `W`: replacement code.
- `unlocked` out 1: level, safe open.
- `lockout` out 1: level, lockout active.
- `match` out 1: one-cycle pulse, correct code.
- `fail` out 1: one-cycle pulse, wrong code.
- `alarm` out 1: one-cycle pulse, lockout entered.

## Operation
- States:
  - RECV: `ser_ready`=1.
  - CHECK: `ser_ready`=0, lasts 1 cycle.
  - OPEN: `ser_ready`=0, `unlocked`=1.
  - LOCK: `ser_ready`=0, `lockout`=1.
- Transfer: a bit is accepted only when `ser_valid && ser_ready`. It is shifted into the code word with `word <= {word[W-2:0], ser_data}`. The bit counter increments, width `$clog2(W)`.
- RECV→CHECK: when the accepted bit is bit `W-1`. The counter returns to 0.
- CHECK→OPEN: if `word == stored`. Pulse `match` and clear the fail counter.
- CHECK→RECV: if the word mismatches and the incremented fail count is below `MAX_TRIES`. Pulse `fail` and keep the incremented count.
- CHECK→LOCK: if the incremented fail count equals `MAX_TRIES`. Pulse `fail` and `alarm` together, clear the fail counter, and load the lockout timer with `LOCKOUT_CYCLES-1`.
- LOCK: the timer decrements every cycle. LOCK→RECV when the timer is 0.
- OPEN→RECV on `relock`.
- `set_code`:
  - Honoured only in OPEN. The stored code is `new_code` from the next cycle.
  - If `set_code` and `relock` are both asserted in the same cycle, both take effect.
- `clear`:
  - In RECV it zeroes the bit counter. It does not count as a failure.
  - If `clear` coincides with an accepted bit, `clear` wins and the bit is discarded.
  - Ignored in other states.
- `ser_valid`/`ser_data` are ignored whenever `ser_ready`=0. Upstream holds the bit.
- Fail counter width is `$clog2(MAX_TRIES+1)`. It saturates only via the lockout path and never wraps.

## Timing
- Reset values:
  - State RECV, so `ser_ready`=1.
  - `unlocked`, `lockout`, `match`, `fail`, `alarm` all 0.
  - Bit count and fail count 0; stored code `RESET_CODE`.
- `rst` mid-entry, in OPEN or in LOCK: everything returns to reset values on the next edge, and the partial word is discarded.
- Latency, with the last bit accepted at edge k:
  - `ser_ready`=0 during cycle k+1 (CHECK).
  - `match`/`fail`/`alarm` high and `unlocked`/`lockout` valid from edge k+2.
- All outputs are registered or decoded from state only. There is no combinational path from inputs to outputs.
- `lockout` is high for exactly `LOCKOUT_CYCLES` cycles. `ser_ready` rises in the cycle after `lockout` falls.
- A continuous `ser_valid` gives `W` bits in `W` cycles. Gaps stall the count without loss.

## Structure
- `lock_pkg`: state enum typedef (`RECV`, `CHECK`, `OPEN`, `LOCK`) and default parameter constants shared with the serializer side.
- One sub-module, `lockout_timer`:
  - Inputs: load, `LOCKOUT_CYCLES` parameter.
  - Outputs: `done` and `active`.
- Shift register, counters and FSM stay in the top module.

## Test plan
All scenarios use the defaults: `N`=4, `DIGITS`=4, `RESET_CODE` 16'h1234.

1. Reset, then send 16'h1234 MSB-first with `ser_valid` held high → `ser_ready` low from cycle 17. Two cycles after the 16th accept, `match` pulses once and `unlocked`=1.
2. Same code with `ser_valid` toggling randomly, while `ser_ready` is also forced low in OPEN → only valid&&ready bits are counted, and the result is identical to scenario 1.
3. Send 16'h0000 three times → `fail` pulses three times; `alarm` pulses with the third. `lockout`=1 for 16 cycles while `ser_valid` is ignored. Sending 16'h1234 afterwards gives `match`.
4. In OPEN, pulse `set_code` with 16'hBEEF plus `relock` in the same cycle → 16'h1234 now gives `fail`, and 16'hBEEF gives `match`.
5. Send 7 bits, pulse `clear` coincident with an 8th valid bit, then send 16'h1234 → `match`. Preceded by one failure, the fail count stays 1: two further wrong codes trigger lockout.
6. Assert `rst` after 5 bits, and again mid-LOCK → next cycle all outputs are 0 and `ser_ready`=1. A stored code of 16'hBEEF reverts to 16'h1234.
